// File: rtl/chan_err_pkg.sv
// Shared types and constants for the channel error injector.
package chan_err_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_ONESHOT  = 2'd2,
    MODE_RANDOM   = 2'd3
  } mode_e;

  localparam int LFSR_W = 16;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 16'hACE1;

endpackage

// File: rtl/err_lfsr.sv
// 16-bit Fibonacci LFSR; shifts left once per step, feedback into bit 0.
module err_lfsr
  import chan_err_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);

  logic fb;
  assign fb = ^(state & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (step) begin
      state <= {state[LFSR_W-2:0], fb};
    end
  end

endmodule

// File: rtl/chan_err_injector.sv
// Channel impairment stage between encoder and Viterbi decoder: corrupts symbols
// in OFF / PERIODIC / ONESHOT / RANDOM mode and keeps saturating statistics.
module chan_err_injector
  import chan_err_pkg::*;
#(
  parameter int          SYM_W     = 2,
  parameter int          POS_W     = 8,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [SYM_W-1:0] sym_i,
  output logic             valid_o,
  output logic [SYM_W-1:0] sym_o,
  output logic             err_flag_o,
  input  logic             cfg_load_i,
  input  logic [1:0]       cfg_mode_i,
  input  logic [POS_W-1:0] cfg_period_i,
  input  logic [POS_W-1:0] cfg_start_i,
  input  logic [POS_W-1:0] cfg_burst_i,
  input  logic [SYM_W-1:0] cfg_mask_i,
  input  logic [7:0]       cfg_thresh_i,
  input  logic             trigger_i,
  input  logic             clr_cnt_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] sym_count_o,
  output logic [CNT_W-1:0] inj_count_o,
  output logic [CNT_W-1:0] bit_count_o
);

  mode_e             cfg_mode;
  logic [POS_W-1:0]  cfg_period, cfg_start, cfg_burst;
  logic [SYM_W-1:0]  cfg_mask;
  logic [7:0]        cfg_thresh;
  logic [POS_W-1:0]  pos, shot, shot_eff, period_m1;
  logic [POS_W:0]    burst_end;
  logic [LFSR_W-1:0] lfsr;
  logic              mode_hit, hit, inj;

  err_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (valid_i),
    .state (lfsr)
  );

  function automatic logic [CNT_W-1:0] popcnt(input logic [SYM_W-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int k = 0; k < SYM_W; k++) c = c + CNT_W'(m[k]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // period=0 gives period_m1 = all-ones, i.e. wrap at 2^POS_W.
  assign period_m1 = cfg_period - POS_W'(1);
  assign burst_end = {1'b0, cfg_start} + {1'b0, cfg_burst};
  assign shot_eff  = (trigger_i && cfg_mode == MODE_ONESHOT) ? cfg_burst : shot;
  assign busy_o    = (shot != '0);

  always_comb begin
    mode_hit = 1'b0;
    case (cfg_mode)
      MODE_PERIODIC: mode_hit = (pos >= cfg_start) && ({1'b0, pos} < burst_end);
      MODE_ONESHOT:  mode_hit = (shot_eff != '0);
      MODE_RANDOM:   mode_hit = (lfsr[7:0] < cfg_thresh);
      default:       mode_hit = 1'b0;
    endcase
  end

  assign hit = valid_i && !cfg_load_i && mode_hit;
  assign inj = hit && (cfg_mask != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o     <= 1'b0;
      sym_o       <= '0;
      err_flag_o  <= 1'b0;
      sym_count_o <= '0;
      inj_count_o <= '0;
      bit_count_o <= '0;
      cfg_mode    <= MODE_OFF;
      cfg_period  <= '0;
      cfg_start   <= '0;
      cfg_burst   <= '0;
      cfg_mask    <= '0;
      cfg_thresh  <= '0;
      pos         <= '0;
      shot        <= '0;
    end else begin
      valid_o    <= valid_i;
      err_flag_o <= inj;
      if (valid_i) sym_o <= sym_i ^ (hit ? cfg_mask : '0);

      sym_count_o <= sat_add(clr_cnt_i ? '0 : sym_count_o, CNT_W'(valid_i));
      inj_count_o <= sat_add(clr_cnt_i ? '0 : inj_count_o, CNT_W'(inj));
      bit_count_o <= sat_add(clr_cnt_i ? '0 : bit_count_o, inj ? popcnt(cfg_mask) : '0);

      if (cfg_load_i) begin
        cfg_mode   <= mode_e'(cfg_mode_i);
        cfg_period <= cfg_period_i;
        cfg_start  <= cfg_start_i;
        cfg_burst  <= cfg_burst_i;
        cfg_mask   <= cfg_mask_i;
        cfg_thresh <= cfg_thresh_i;
        pos        <= '0;
        shot       <= '0;
      end else begin
        if (valid_i) pos <= (pos == period_m1) ? '0 : pos + POS_W'(1);
        shot <= (valid_i && shot_eff != '0) ? shot_eff - POS_W'(1) : shot_eff;
      end
    end
  end

endmodule

// File: tb/tb_chan_err_injector.sv
// Scoreboard bench: driver pushes expected {sym, err} per valid symbol, monitor pops on valid_o.
module tb_chan_err_injector;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_i;
  logic [1:0] sym_i;
  logic       cfg_load_i;
  logic [1:0] cfg_mode_i;
  logic [7:0] cfg_period_i, cfg_start_i, cfg_burst_i, cfg_thresh_i;
  logic [1:0] cfg_mask_i;
  logic       trigger_i, clr_cnt_i;

  logic        valid_o, err_flag_o, busy_o;
  logic [1:0]  sym_o;
  logic [15:0] sym_count_o, inj_count_o, bit_count_o;

  logic        s_valid_o, s_err_flag_o, s_busy_o;
  logic [1:0]  s_sym_o;
  logic [3:0]  s_sym_count_o, s_inj_count_o, s_bit_count_o;

  int total = 0;
  int bad   = 0;
  logic [2:0]  exp_q[$];
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  chan_err_injector #(.SYM_W(2), .POS_W(8), .CNT_W(16), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .sym_i(sym_i),
    .valid_o(valid_o), .sym_o(sym_o), .err_flag_o(err_flag_o),
    .cfg_load_i(cfg_load_i), .cfg_mode_i(cfg_mode_i), .cfg_period_i(cfg_period_i),
    .cfg_start_i(cfg_start_i), .cfg_burst_i(cfg_burst_i), .cfg_mask_i(cfg_mask_i),
    .cfg_thresh_i(cfg_thresh_i), .trigger_i(trigger_i), .clr_cnt_i(clr_cnt_i),
    .busy_o(busy_o), .sym_count_o(sym_count_o), .inj_count_o(inj_count_o),
    .bit_count_o(bit_count_o)
  );

  // Narrow-counter copy on the same stimulus, for saturation.
  chan_err_injector #(.SYM_W(2), .POS_W(8), .CNT_W(4), .LFSR_SEED(16'hACE1)) u_sat (
    .clk(clk), .rst(rst), .valid_i(valid_i), .sym_i(sym_i),
    .valid_o(s_valid_o), .sym_o(s_sym_o), .err_flag_o(s_err_flag_o),
    .cfg_load_i(cfg_load_i), .cfg_mode_i(cfg_mode_i), .cfg_period_i(cfg_period_i),
    .cfg_start_i(cfg_start_i), .cfg_burst_i(cfg_burst_i), .cfg_mask_i(cfg_mask_i),
    .cfg_thresh_i(cfg_thresh_i), .trigger_i(trigger_i), .clr_cnt_i(clr_cnt_i),
    .busy_o(s_busy_o), .sym_count_o(s_sym_count_o), .inj_count_o(s_inj_count_o),
    .bit_count_o(s_bit_count_o)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid_o", 1, 0);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        chk("sym_err_out", {sym_o, err_flag_o}, e);
      end
    end
  end

  // One cycle of stimulus; xm is the XOR pattern the symbol is expected to receive.
  task automatic cyc(input bit v, input logic [1:0] s, input logic [1:0] xm,
                     input bit trig = 0, input bit clr = 0, input bit load = 0);
    logic fb;
    @(negedge clk);
    valid_i    = v;
    sym_i      = s;
    trigger_i  = trig;
    clr_cnt_i  = clr;
    cfg_load_i = load;
    if (v) begin
      exp_q.push_back({s ^ xm, xm != 2'b00});
      fb     = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
      m_lfsr = {m_lfsr[14:0], fb};
    end
  endtask

  task automatic cfg(input logic [1:0] m, input logic [7:0] per, input logic [7:0] st,
                     input logic [7:0] bu, input logic [1:0] mk, input logic [7:0] th);
    cfg_mode_i   = m;
    cfg_period_i = per;
    cfg_start_i  = st;
    cfg_burst_i  = bu;
    cfg_mask_i   = mk;
    cfg_thresh_i = th;
    cyc(0, 2'b00, 2'b00, 0, 0, 1);
    cyc(0, 2'b00, 2'b00, 0, 1, 0);
  endtask

  task automatic chk_cnt(input string nm, input int es, input int ei, input int eb);
    cyc(0, 2'b00, 2'b00);
    chk({nm, "_sym"}, sym_count_o, es);
    chk({nm, "_inj"}, inj_count_o, ei);
    chk({nm, "_bit"}, bit_count_o, eb);
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_valid_o"}, valid_o, 0);
    chk({nm, "_sym_o"}, sym_o, 0);
    chk({nm, "_err"}, err_flag_o, 0);
    chk({nm, "_busy"}, busy_o, 0);
    chk({nm, "_cnt"}, {sym_count_o, inj_count_o, bit_count_o}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [1:0] xm;
    rst = 1'b1; valid_i = 0; sym_i = 0; cfg_load_i = 0; cfg_mode_i = 0;
    cfg_period_i = 0; cfg_start_i = 0; cfg_burst_i = 0; cfg_mask_i = 0;
    cfg_thresh_i = 0; trigger_i = 0; clr_cnt_i = 0;
    m_lfsr = 16'hACE1;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;

    // PERIODIC 32/10/4, bit0 flipped at pos 10..13
    cfg(2'd1, 8'd32, 8'd10, 8'd4, 2'b01, 8'd0);
    for (int i = 0; i < 256; i++)
      cyc(1, i[1:0], ((i % 32) >= 10 && (i % 32) < 14) ? 2'b01 : 2'b00);
    chk_cnt("periodic", 256, 32, 32);

    // ONESHOT burst 5 mask 11, valid every other cycle
    cfg(2'd2, 8'd0, 8'd0, 8'd5, 2'b11, 8'd0);
    cyc(0, 2'b00, 2'b00, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 2'b00, 2'b00);
      chk("oneshot_busy_hi", busy_o, 1);
      cyc(1, k[1:0], 2'b11);
    end
    cyc(0, 2'b00, 2'b00);
    chk("oneshot_busy_lo", busy_o, 0);
    cyc(1, 2'b10, 2'b00);
    chk_cnt("oneshot", 6, 5, 10);

    // Retrigger after 3 hits; retrigger coincides with a valid symbol
    cyc(0, 2'b00, 2'b00, 0, 1);
    cyc(0, 2'b00, 2'b00, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 2'b00, 2'b00);
      cyc(1, k[1:0], 2'b11);
    end
    cyc(1, 2'b01, 2'b11, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 2'b00, 2'b00);
      cyc(1, k[1:0], 2'b11);
    end
    cyc(0, 2'b00, 2'b00);
    chk("retrig_busy_lo", busy_o, 0);
    cyc(1, 2'b11, 2'b00);
    chk_cnt("retrig", 9, 8, 16);

    // Trigger with burst=0 never arms
    cfg(2'd2, 8'd0, 8'd0, 8'd0, 2'b11, 8'd0);
    cyc(0, 2'b00, 2'b00, 1);
    cyc(1, 2'b01, 2'b00);
    chk("burst0_busy", busy_o, 0);

    // RANDOM thresh=0 then thresh=128
    cfg(2'd3, 8'd0, 8'd0, 8'd0, 2'b10, 8'd0);
    for (int i = 0; i < 1000; i++) cyc(1, i[1:0], 2'b00);
    chk_cnt("rand_t0", 1000, 0, 0);
    cfg(2'd3, 8'd0, 8'd0, 8'd0, 2'b10, 8'd128);
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      xm = (m_lfsr[7:0] < 8'd128) ? 2'b10 : 2'b00;
      if (xm != 2'b00) cnt++;
      cyc(1, i[1:0], xm);
    end
    chk_cnt("rand_t128", 1000, cnt, cnt);

    // period=0 start=250 burst=10: truncated to 250..255
    cfg(2'd1, 8'd0, 8'd250, 8'd10, 2'b01, 8'd0);
    for (int i = 0; i < 256; i++) cyc(1, i[1:0], (i >= 250) ? 2'b01 : 2'b00);
    chk_cnt("trunc", 256, 6, 6);

    // start beyond period: never hits
    cfg(2'd1, 8'd32, 8'd40, 8'd4, 2'b01, 8'd0);
    for (int i = 0; i < 64; i++) cyc(1, i[1:0], 2'b00);
    chk_cnt("start_gt_period", 64, 0, 0);

    // Saturation on the 4-bit copy, then clear with a coincident hit
    cfg(2'd1, 8'd32, 8'd0, 8'd32, 2'b01, 8'd0);
    for (int i = 0; i < 20; i++) cyc(1, i[1:0], 2'b01);
    chk_cnt("sat_wide", 20, 20, 20);
    chk("sat_inj", s_inj_count_o, 15);
    chk("sat_bit", s_bit_count_o, 15);
    chk("sat_sym", s_sym_count_o, 15);
    cyc(1, 2'b11, 2'b01, 0, 1);
    chk_cnt("clr_hit", 1, 1, 1);
    chk("clr_hit_sat_inj", s_inj_count_o, 1);

    // cfg_load_i coincident with valid mid-burst: passes clean, pos restarts
    cfg(2'd1, 8'd32, 8'd2, 8'd3, 2'b11, 8'd0);
    cyc(1, 2'b00, 2'b00);
    cyc(1, 2'b01, 2'b00);
    cyc(1, 2'b10, 2'b11);
    cyc(1, 2'b11, 2'b11);
    cyc(1, 2'b01, 2'b00, 0, 0, 1);
    cyc(1, 2'b10, 2'b00);
    cyc(1, 2'b11, 2'b00);
    cyc(1, 2'b00, 2'b11);
    chk_cnt("load_mid", 8, 3, 6);

    // rst mid-burst
    cfg(2'd2, 8'd0, 8'd0, 8'd10, 2'b11, 8'd0);
    cyc(0, 2'b00, 2'b00, 1);
    cyc(1, 2'b01, 2'b11);
    cyc(1, 2'b10, 2'b11);
    @(negedge clk);
    rst = 1'b1; valid_i = 0; trigger_i = 0; clr_cnt_i = 0; cfg_load_i = 0;
    m_lfsr = 16'hACE1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state("midrst");
    cyc(1, 2'b01, 2'b00, 1);
    cyc(1, 2'b10, 2'b00);
    chk("midrst_busy", busy_o, 0);
    chk_cnt("midrst", 2, 0, 0);

    cyc(0, 2'b00, 2'b00);
    cyc(0, 2'b00, 2'b00);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chan_err_injector.md
Name: chan_err_injector

Overview:
Parametrised channel-impairment stage inserted between the convolutional encoder output and the Viterbi decoder input in the tx/rx test harness. Corrupts encoded symbols in one of four run-time modes: off, periodic burst, triggered one-shot burst, or LFSR pseudo-random. Keeps saturating statistics so decoder correction capability is measured in RTL, not by testbench prints. Replaces the hard-coded "flip bit 0 at positions 10..13 of every 32" injector.

Parameters:
SYM_W, 2, encoded symbol width (code rate 1/SYM_W)
POS_W, 8, width of position/period/start/burst fields
CNT_W, 16, width of statistic counters
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_i  in  1  symbol strobe from encoder
sym_i  in  SYM_W  encoded symbol
valid_o  out  1  valid_i delayed one cycle
sym_o  out  SYM_W  possibly corrupted symbol, to decoder
err_flag_o  out  1  high with valid_o when sym_o differs from the input symbol
cfg_load_i  in  1  latch all cfg_* inputs
cfg_mode_i  in  2  0 OFF, 1 PERIODIC, 2 ONESHOT, 3 RANDOM
cfg_period_i  in  POS_W  burst period in symbols; 0 means 2^POS_W
cfg_start_i  in  POS_W  first corrupted position within period
cfg_burst_i  in  POS_W  burst length in symbols
cfg_mask_i  in  SYM_W  XOR mask applied to corrupted symbols
cfg_thresh_i  in  8  RANDOM mode: corrupt if lfsr[7:0] < thresh
trigger_i  in  1  ONESHOT: arm a burst
clr_cnt_i  in  1  clear statistic counters
busy_o  out  1  ONESHOT burst pending/active
sym_count_o  out  CNT_W  valid symbols seen
inj_count_o  out  CNT_W  corrupted symbols
bit_count_o  out  CNT_W  flipped bits (sum of popcount(mask))

Behaviour:
- Reset: valid_o=0, sym_o=0, err_flag_o=0, busy_o=0, all counters 0, mode=OFF, cfg regs 0, pos=0, lfsr=LFSR_SEED.
- Latency exactly 1 cycle: valid_o<=valid_i; sym_o<=sym_i^(hit?mask:0); err_flag_o<=valid_i&hit&(mask!=0). sym_o updates only when valid_i=1, else holds.
- pos advances only on valid_i; wraps to 0 after period-1 (after 2^POS_W-1 when period=0).
- PERIODIC: hit when start<=pos<start+burst, compared at POS_W+1 bits (no wrap; a burst past period end is truncated). burst=0 or start>=period: never hits.
- ONESHOT: trigger_i loads shot=burst, busy_o=1; each valid symbol with shot>0 hits and decrements; busy_o falls when shot reaches 0. Trigger during a burst restarts it at full length. Trigger with burst=0: busy_o stays 0. trigger_i and valid_i in the same cycle: that symbol is the first hit.
- RANDOM: 16-bit Fibonacci LFSR, taps 16,14,13,11, steps once per valid symbol; hit uses the pre-step value. thresh=0: never hits; 255: hits unless lfsr[7:0]=255.
- OFF: pass-through; pos and lfsr still advance.
- cfg_load_i: takes priority; latches all cfg fields, pos<=0, shot<=0, busy_o<=0; lfsr not reseeded. A symbol coincident with cfg_load_i passes uncorrupted (hit=0) but is counted in sym_count_o.
- Counters saturate at all-ones. clr_cnt_i zeroes them, then adds the current cycle's event (result 0 or increment value).
- rst mid-burst: all state to reset values next edge; no partial burst resumes.

Decomposition:
- Package chan_err_pkg: mode enum (MODE_OFF, MODE_PERIODIC, MODE_ONESHOT, MODE_RANDOM), LFSR width and tap constant, default seed.
- Sub-module err_lfsr (clk, rst, step, state out, seed parameter). Popcount and saturating adders inline.

Test Plan:
- PERIODIC period=32 start=10 burst=4 mask=2'b01, 256 contiguous valid symbols -> sym_o bit0 inverted exactly at pos 10..13 of each period; inj_count=32, bit_count=32, sym_count=256.
- ONESHOT burst=5 mask=2'b11, trigger, valid every other cycle -> next 5 valid symbols both bits flipped; busy_o high 5 valid symbols; retrigger after 3 -> 8 hits total, bit_count=16.
- RANDOM thresh=0 over 1000 symbols -> inj_count=0; thresh=128 -> inj_count equals reference-model LFSR count from seed 16'hACE1.
- Edge: period=0 start=250 burst=10 -> hits at pos 250..255 only (truncation), 6 per 256 symbols; start=40 period=32 -> no hits.
- Saturation/clear: CNT_W=4, 20 hits -> inj_count=15; clr_cnt_i with a hit same cycle -> inj_count=1.
- cfg_load_i coincident with valid_i mid-burst, then rst mid-burst -> that symbol unmodified, pos restarts at 0; after rst all outputs 0, mode OFF.
